// File: rtl/pb_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, one-cycle press pulse (BC) and debounced level.
// Optional AUTO_REPEAT_EN macro adds hold-to-repeat pulses on BC.
module pb_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic B,
    output logic BC,
    output logic level
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_n;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             bc_n, level_n;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // rep marks that the first (delayed) repeat has fired; later ones use the period.
    logic [CNT_W-1:0] rcnt, rcnt_n;
    logic             rep, rep_n;
`else
    // Repeat timing parameters are inert when repeats are compiled out.
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_repeat_inert
    end
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bc_n    = 1'b0;
        level_n = level;
`ifdef AUTO_REPEAT_EN
        rcnt_n  = rcnt;
        rep_n   = rep;
`endif
        case (state)
            IDLE: begin
                if (s2) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = PRESSED;
                    bc_n    = 1'b1;
                    level_n = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rcnt_n  = '0;
                    rep_n   = 1'b0;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end
`ifdef AUTO_REPEAT_EN
                else if (!rep && rcnt == DELAY_LAST) begin
                    bc_n   = 1'b1;
                    rep_n  = 1'b1;
                    rcnt_n = '0;
                end else if (rep && rcnt == PERIOD_LAST) begin
                    bc_n   = 1'b1;
                    rcnt_n = '0;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_n = PRESSED;
`ifdef AUTO_REPEAT_EN
                    rcnt_n  = '0;
                    rep_n   = 1'b0;
`endif
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    level_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            BC    <= 1'b0;
            level <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt  <= '0;
            rep   <= 1'b0;
`endif
        end else begin
            s1    <= B;
            s2    <= s1;
            state <= state_n;
            cnt   <= cnt_n;
            BC    <= bc_n;
            level <= level_n;
`ifdef AUTO_REPEAT_EN
            rcnt  <= rcnt_n;
            rep   <= rep_n;
`endif
        end
    end

endmodule

// File: tb/tb_pb_debounce_pulse.sv
// Scoreboard bench for pb_debounce_pulse: a run-length reference model queues expected BC edges,
// a negedge monitor pops them when BC fires and tracks the debounced level.
module tb_pb_debounce_pulse;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic rst;
    logic B;
    logic BC;
    logic level;

    int edge_n = 0;
    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int model_pulses = 0;
    int dut_pulses = 0;
    int last_bc_edge = -1;

    // Reference model: two-sample delay line, debounced level, run of disagreeing samples, hold time.
    bit p1, p2, ml, sv;
    int run = 0;
    int hold = 0;

    pb_debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(6),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .B(B),
        .BC(BC),
        .level(level)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            p1 = 1'b0; p2 = 1'b0; ml = 1'b0; run = 0; hold = 0;
        end else begin
            sv = p2;
            if (sv != ml) begin
                run++;
                if (run == D + 1) begin
                    ml = sv; run = 0; hold = 0;
                    if (sv) begin exp_q.push_back(edge_n); model_pulses++; end
                end
            end else begin
                if (ml && run > 0) hold = 0;
                else if (ml) begin
                    hold++;
`ifdef AUTO_REPEAT_EN
                    if (hold >= RD && (hold - RD) % RP == 0) begin
                        exp_q.push_back(edge_n); model_pulses++;
                    end
`endif
                end
                run = 0;
            end
            p2 = p1;
            p1 = B;
        end
    end

    always @(negedge clk) begin
        int e;
        if (edge_n >= 1) begin
            checks++;
            if ($isunknown({BC, level})) begin
                failures++;
                $display("FAIL no_x: BC=%b level=%b at edge %0d, required known values", BC, level, edge_n);
            end
            checks++;
            if (level !== ml) begin
                failures++;
                $display("FAIL level: got %b required %b at edge %0d", level, ml, edge_n);
            end
            if (BC === 1'b1) begin
                dut_pulses++;
                last_bc_edge = edge_n;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_bc: BC=1 after edge %0d, required 0", edge_n);
                end else begin
                    e = exp_q.pop_front();
                    if (e != edge_n) begin
                        failures++;
                        $display("FAIL bc_edge: pulse after edge %0d, required after edge %0d", edge_n, e);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0] <= edge_n) begin
                checks++;
                failures++;
                e = exp_q.pop_front();
                $display("FAIL missing_bc: BC=0 after edge %0d, required 1 (expected edge %0d)", edge_n, e);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic drive(input bit b, input int n);
        B = b;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int start, snap, len;
        bit b;
        rst = 1'b1;
        B   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_level", int'(level), 0);
        chk("reset_bc", int'(BC), 0);

        // Clean press and release.
        drive(1'b0, 5);
        start = edge_n + 1;
        snap  = dut_pulses;
        drive(1'b1, 16);
        chk("press_edge", last_bc_edge, start + D + 2);
        chk("press_count", dut_pulses - snap, 1);
        chk("press_level", int'(level), 1);
        drive(1'b0, 14);
        chk("release_level", int'(level), 0);

        // Bouncy press.
        for (int i = 0; i < 4; i++) drive(i % 2 == 0, 3);
        start = edge_n + 1;
        snap  = dut_pulses;
        drive(1'b1, 16);
        chk("bounce_edge", last_bc_edge, start + D + 2);
        chk("bounce_count", dut_pulses - snap, 1);

        // Short release bounce keeps the press; long low releases it.
        snap = dut_pulses;
        drive(1'b0, 4);
        drive(1'b1, 6);
        chk("rel_bounce_level", int'(level), 1);
        chk("rel_bounce_count", dut_pulses - snap, 0);
        drive(1'b0, 20);
        chk("rel_long_level", int'(level), 0);

        // Reset in the middle of a press debounce with B held high.
        drive(1'b1, 7);
        snap = dut_pulses;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start = edge_n + 1;
        drive(1'b1, 16);
        chk("rst_mid_count", dut_pulses - snap, 1);
        chk("rst_mid_edge", last_bc_edge, start + D + 2);
        drive(1'b0, 20);

        // Long hold: repeats at +20, +25, +30, +35 when enabled.
        start = edge_n + 1;
        snap  = dut_pulses;
        drive(1'b1, 46);
`ifdef AUTO_REPEAT_EN
        chk("hold_count", dut_pulses - snap, 5);
        chk("hold_last_edge", last_bc_edge, start + D + 2 + RD + 3 * RP);
`else
        chk("hold_count", dut_pulses - snap, 1);
`endif
        snap = dut_pulses;
        drive(1'b0, 20);
        chk("after_release_count", dut_pulses - snap, 0);

        // Randomised bursts with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            drive(b, len);
        end
        drive(1'b0, 30);

        chk("queue_drained", exp_q.size(), 0);
        chk("pulse_total", dut_pulses, model_pulses);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
